add_seq_ctrl: RTL
=================

# add_seq_ctrl

Multi-cycle sequencer that adds two WIDTH-bit operands by reusing a single 4-bit ripple-carry adder slice, one nibble per clock, least significant nibble first. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. It gives area-constrained datapaths wide addition from one shared 4-bit slice, with the carry held in a register between nibbles.

## Interface
Parameters:
- WIDTH, 16, operand and result width; must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, number of nibble steps (derived; do not override).

Ports:
- clk  in  1  rising-edge clock for the single clock domain.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  producer offers operands.
- in_ready  out  1  block accepts operands (high only in IDLE).
- a  in  WIDTH  operand A, sampled at the accept edge.
- b  in  WIDTH  operand B, sampled at the accept edge.
- cin  in  1  carry-in, sampled at the accept edge.
- out_valid  out  1  result available (high only in DONE).
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  registered result, (a+b+cin) mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  two's-complement overflow: a[MSB]==b[MSB] and sum[MSB]!=a[MSB].
- busy  out  1  high in RUN or DONE.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, latch a, b and cin into operand registers, set idx=0 and carry_q=cin, and go to RUN.
- RUN:
  - The slice computes {c, s} = a_q[idx*4+:4] + b_q[idx*4+:4] + carry_q.
  - sum_q[idx*4+:4] <= s and carry_q <= c.
  - If idx==NIB-1: cout <= c, ovf <= computed from the latched operands and the final sum MSB, go to DONE. Otherwise idx <= idx+1.
  - in_valid is ignored.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable.
  - On out_ready, go to IDLE. in_ready stays 0 in DONE, so there is no same-cycle accept.
- Arithmetic: unsigned modulo 2^WIDTH. The carry never propagates beyond one nibble per cycle. No combinational path from a or b to sum.
- Reset, including mid-RUN or mid-DONE:
  - The FSM goes to IDLE and idx=0.
  - sum=0, cout=0, ovf=0, out_valid=0, busy=0, in_ready=1.
  - Any in-flight operation is discarded without producing a result.
- Operands held in the input registers are not affected by changes on a and b after the accept edge.

## Timing
- The accept edge is E0. RUN covers the cycles after edges E0..E0+NIB-1. DONE is entered at edge E0+NIB, and out_valid is first high in the cycle following E0+NIB.
- Latency: NIB+1 edges from accept to out_valid (5 edges for WIDTH=16).
- Minimum issue interval: NIB+2 cycles (one IDLE cycle between operations).
- out_valid and the result are held for as long as out_ready stays low. There is no timeout.
- in_ready and out_valid are decoded from registered state only.

## Structure
- Package add_seq_pkg holds:
  - the state_t enum {IDLE, RUN, DONE};
  - the constant NIB_BITS = $clog2(NIB) (a parameterised function);
  - the shared nibble width constant SLICE_W = 4.
- Sub-module add4_slice: a combinational 4-bit ripple full-adder slice with ports a, b, cin, sum, cout.
  - It is instantiated exactly once.
  - The controller owns all registers: the operand registers, idx, carry_q and sum_q.

## Test plan
- WIDTH=16: a=0x00FF, b=0x0001, cin=0 -> sum=0x0100, cout=0, ovf=0. out_valid must be high in the cycle after E0+4, and in_ready low for the whole operation.
- a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. This checks carry propagation through all 4 nibbles.
- a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1. Then a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid rises, and drive in_valid=1 with new operands during that time. The result must stay stable, no new accept may occur, and IDLE is reached on the edge where out_ready=1.
- Reset mid-RUN: assert rst two cycles after E0. All outputs must go to 0 immediately, with in_ready=1. After release, an add of 0x0003+0x0004 must complete with sum=0x0007.
- Back-to-back: issue 3 random operations with in_valid held high and out_ready=1. Each result must match a reference model, and each issue interval must be exactly NIB+2 cycles.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared types and constants for the nibble-serial adder sequencer.
package add_seq_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Width of the nibble index; never narrower than one bit.
  function automatic int nib_bits(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/add_seq_ctrl_add4_slice.sv
// Combinational 4-bit ripple-carry full-adder slice shared by every nibble step.
module add4_slice
  import add_seq_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic c;

  // NOTE: blocking assignments here are deliberate; the carry ripples through
  // the loop within one evaluation, which is exactly combinational logic.
  always_comb begin
    sum = '0;
    c   = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/add_seq_ctrl.sv
// Sequencer adding two WIDTH-bit operands one nibble per clock through a single
// shared 4-bit slice, with valid/ready handshakes on both sides.
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NIB   = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIB_BITS = nib_bits(NIB);
  localparam int W_BITS   = $clog2(WIDTH);

  state_t               state_q, state_d;
  logic [NIB_BITS-1:0]  idx_q;
  logic [WIDTH-1:0]     a_q, b_q, sum_q;
  logic                 carry_q, cout_q, ovf_q;

  logic [W_BITS-1:0]    base;
  logic [SLICE_W-1:0]   slice_sum;
  logic                 slice_cout;
  logic                 last;

  assign base = W_BITS'(int'(idx_q) * SLICE_W);
  assign last = (idx_q == NIB_BITS'(NIB - 1));

  add4_slice u_slice (
    .a    (a_q[base +: SLICE_W]),
    .b    (b_q[base +: SLICE_W]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output is given a default before the case so no path through
  // this block leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = RUN;
      end
      RUN:  if (last) state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers; all owned here so the slice stays purely combinational.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          b_q     <= b;
          carry_q <= cin;
          idx_q   <= '0;
        end
        RUN: begin
          sum_q[base +: SLICE_W] <= slice_sum;
          carry_q                <= slice_cout;
          if (last) begin
            cout_q <= slice_cout;
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                      (slice_sum[SLICE_W-1] != a_q[WIDTH-1]);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
